// File: rtl/t03_combat_pkg.sv
// t03_combat_pkg
// Shared encodings and widths for the combat arbiter slice.
//   - Game-state encoding (IDLE/FIGHT/P1_WIN/P2_WIN/DRAW), 3 bits.
//   - Player-state encoding (REST/ATTACK/BLOCK); 2'b11 is invalid and reads as rest.
//   - Health width 4, time width 12, plus matching types.
//   - BlockDamage: damage dealt to a blocking player. Set by macro T03_CHIP_DAMAGE_EN
//     (defined: 1, chip damage with hit pulse; undefined: 0, full block).
//   - sat_sub: health subtraction clamped at zero.
package t03_combat_pkg;

  localparam int unsigned HealthW = 4;
  localparam int unsigned TimeW   = 12;

  typedef logic [HealthW-1:0] health_t;
  typedef logic [TimeW-1:0]   time_t;

  localparam logic [2:0] GameIdle  = 3'b000;
  localparam logic [2:0] GameFight = 3'b001;
  localparam logic [2:0] GameP1Win = 3'b010;
  localparam logic [2:0] GameP2Win = 3'b011;
  localparam logic [2:0] GameDraw  = 3'b100;

  localparam logic [1:0] PlayerRest   = 2'b00;
  localparam logic [1:0] PlayerAttack = 2'b01;
  localparam logic [1:0] PlayerBlock  = 2'b10;

`ifdef T03_CHIP_DAMAGE_EN
  localparam int unsigned BlockDamage = 1;
`else
  localparam int unsigned BlockDamage = 0;
`endif

  // Clamp at zero so a large hit on low health never wraps.
  function automatic health_t sat_sub(input health_t h, input health_t d);
    return (h > d) ? health_t'(h - d) : '0;
  endfunction

endpackage

// File: rtl/t03_attack_edge.sv
// t03_attack_edge
// Tick-gated rising-edge detector on "player is attacking" (state == 01).
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset; history reads "not attacking"
//   tick_i     frame tick; history only advances when 1
//   clear_i    round start: suppress the edge this tick; history then holds the
//              current state, so a 01 held across the start does not strike
//   state_i    2-bit player state
//   edge_o     combinational: attacking now and not attacking on the previous tick
module t03_attack_edge
  import t03_combat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       clear_i,
  input  logic [1:0] state_i,
  output logic       edge_o
);

  logic attacking;
  logic attack_q;

  assign attacking = (state_i == PlayerAttack);
  assign edge_o    = attacking & ~attack_q & ~clear_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      attack_q <= 1'b0;
    end else if (tick_i) begin
      attack_q <= attacking;
    end
  end

endmodule

// File: rtl/t03_combat_arbiter.sv
// t03_combat_arbiter
// Two-player combat round arbiter. All state advances on ticks (finished = 1) and
// every output is registered, so a tick's effect is visible the following cycle.
// Optional feature: macro T03_CHIP_DAMAGE_EN gives a blocking player 1 point of chip
// damage (with hit pulse); without it a block absorbs the strike entirely.
// Parameters:
//   MAX_HEALTH   health loaded at round start
//   HIT_DAMAGE   damage of an unblocked strike
//   ROUND_TICKS  round length in ticks
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   finished               frame tick
//   start                  level, sampled on ticks; starts a round unless in FIGHT
//   p1_state, p2_state     00 rest, 01 attack, 10 block, 11 treated as rest
//   p1_health, p2_health   current health
//   hit_p1, hit_p2         player was struck with nonzero damage on the last tick
//   game_state             000 IDLE, 001 FIGHT, 010 P1_WIN, 011 P2_WIN, 100 DRAW
//   time_left              remaining round ticks
module t03_combat_arbiter
  import t03_combat_pkg::*;
#(
  parameter int unsigned MAX_HEALTH  = 10,
  parameter int unsigned HIT_DAMAGE  = 2,
  parameter int unsigned ROUND_TICKS = 3600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        finished,
  input  logic        start,
  input  logic [1:0]  p1_state,
  input  logic [1:0]  p2_state,
  output logic [3:0]  p1_health,
  output logic [3:0]  p2_health,
  output logic        hit_p1,
  output logic        hit_p2,
  output logic [2:0]  game_state,
  output logic [11:0] time_left
);

  localparam health_t MaxHealthV = health_t'(MAX_HEALTH);
  localparam health_t HitDmgV    = health_t'(HIT_DAMAGE);
  localparam health_t BlockDmgV  = health_t'(BlockDamage);
  localparam time_t   RoundV     = time_t'(ROUND_TICKS);

  logic [2:0] gs_q, gs_d;
  health_t    h1_q, h1_d, h2_q, h2_d;
  logic       hit1_q, hit1_d, hit2_q, hit2_d;
  time_t      tl_q, tl_d;

  logic    in_fight;
  logic    begin_round;
  logic    p1_edge, p2_edge;
  health_t dmg_to_p1, dmg_to_p2;
  health_t h1_after, h2_after;
  time_t   tl_after;

  assign in_fight    = (gs_q == GameFight);
  assign begin_round = finished & start & ~in_fight;

  t03_attack_edge u_edge_p1 (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (finished),
    .clear_i (begin_round),
    .state_i (p1_state),
    .edge_o  (p1_edge)
  );

  t03_attack_edge u_edge_p2 (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (finished),
    .clear_i (begin_round),
    .state_i (p2_state),
    .edge_o  (p2_edge)
  );

  // Blocking is judged on the states sampled this tick; a player with an attack
  // edge is in 01, so simultaneous attackers never block each other.
  always_comb begin
    dmg_to_p1 = '0;
    dmg_to_p2 = '0;
    if (p2_edge) dmg_to_p1 = (p1_state == PlayerBlock) ? BlockDmgV : HitDmgV;
    if (p1_edge) dmg_to_p2 = (p2_state == PlayerBlock) ? BlockDmgV : HitDmgV;
  end

  assign h1_after = sat_sub(h1_q, dmg_to_p1);
  assign h2_after = sat_sub(h2_q, dmg_to_p2);
  assign tl_after = (tl_q == '0) ? '0 : time_t'(tl_q - time_t'(1));

  always_comb begin
    gs_d   = gs_q;
    h1_d   = h1_q;
    h2_d   = h2_q;
    hit1_d = hit1_q;
    hit2_d = hit2_q;
    tl_d   = tl_q;
    if (finished) begin
      if (begin_round) begin
        gs_d   = GameFight;
        h1_d   = MaxHealthV;
        h2_d   = MaxHealthV;
        hit1_d = 1'b0;
        hit2_d = 1'b0;
        tl_d   = RoundV;
      end else if (in_fight) begin
        h1_d   = h1_after;
        h2_d   = h2_after;
        hit1_d = (dmg_to_p1 != '0);
        hit2_d = (dmg_to_p2 != '0);
        tl_d   = tl_after;
        // Exit is judged on post-damage health, knockouts before the timer.
        if (h1_after == '0 && h2_after == '0) begin
          gs_d = GameDraw;
        end else if (h2_after == '0) begin
          gs_d = GameP1Win;
        end else if (h1_after == '0) begin
          gs_d = GameP2Win;
        end else if (tl_after == '0) begin
          if (h1_after > h2_after) begin
            gs_d = GameP1Win;
          end else if (h2_after > h1_after) begin
            gs_d = GameP2Win;
          end else begin
            gs_d = GameDraw;
          end
        end
      end else begin
        // IDLE and result states: everything frozen, no strikes.
        hit1_d = 1'b0;
        hit2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gs_q   <= GameIdle;
      h1_q   <= MaxHealthV;
      h2_q   <= MaxHealthV;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      tl_q   <= RoundV;
    end else begin
      gs_q   <= gs_d;
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
      tl_q   <= tl_d;
    end
  end

  assign p1_health  = h1_q;
  assign p2_health  = h2_q;
  assign hit_p1     = hit1_q;
  assign hit_p2     = hit2_q;
  assign game_state = gs_q;
  assign time_left  = tl_q;

endmodule

// File: tb/tb_t03_combat_arbiter.sv
module tb_t03_combat_arbiter;
  import t03_combat_pkg::*;

`ifdef T03_CHIP_DAMAGE_EN
  localparam int BD = 1;
`else
  localparam int BD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       finished = 1'b1;
  logic       start = 1'b0;
  logic [1:0] p1 = 2'b00;
  logic [1:0] p2 = 2'b00;

  logic [3:0]  a_h1, a_h2, b_h1, b_h2;
  logic        a_x1, a_x2, b_x1, b_x2;
  logic [2:0]  a_gs, b_gs;
  logic [11:0] a_tl, b_tl;

  always #5 clk = ~clk;

  t03_combat_arbiter dut_a (
    .clk(clk), .rst(rst_a), .finished(finished), .start(start),
    .p1_state(p1), .p2_state(p2), .p1_health(a_h1), .p2_health(a_h2),
    .hit_p1(a_x1), .hit_p2(a_x2), .game_state(a_gs), .time_left(a_tl)
  );

  t03_combat_arbiter #(.ROUND_TICKS(4)) dut_b (
    .clk(clk), .rst(rst_b), .finished(finished), .start(start),
    .p1_state(p1), .p2_state(p2), .p1_health(b_h1), .p2_health(b_h2),
    .hit_p1(b_x1), .hit_p2(b_x2), .game_state(b_gs), .time_left(b_tl)
  );

  typedef struct {
    int          due;
    bit          sel;
    string       name;
    logic [3:0]  h1;
    logic [3:0]  h2;
    logic        x1;
    logic        x2;
    logic [2:0]  gs;
    logic [11:0] tl;
  } exp_t;

  exp_t sb[$];
  int   pcnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) pcnt <= pcnt + 1;

  // Monitor: compares every expectation that has come due at this falling edge.
  exp_t        e;
  logic [3:0]  g_h1, g_h2;
  logic        g_x1, g_x2;
  logic [2:0]  g_gs;
  logic [11:0] g_tl;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= pcnt) begin
      e = sb.pop_front();
      if (e.sel) begin
        g_h1 = b_h1; g_h2 = b_h2; g_x1 = b_x1; g_x2 = b_x2; g_gs = b_gs; g_tl = b_tl;
      end else begin
        g_h1 = a_h1; g_h2 = a_h2; g_x1 = a_x1; g_x2 = a_x2; g_gs = a_gs; g_tl = a_tl;
      end
      n_checks = n_checks + 1;
      if (g_h1 !== e.h1 || g_h2 !== e.h2 || g_x1 !== e.x1 || g_x2 !== e.x2 ||
          g_gs !== e.gs || g_tl !== e.tl) begin
        n_errors = n_errors + 1;
        $display("FAIL %s: got h1=%0d h2=%0d hit=%b%b gs=%0d tl=%0d, want h1=%0d h2=%0d hit=%b%b gs=%0d tl=%0d",
                 e.name, g_h1, g_h2, g_x1, g_x2, g_gs, g_tl,
                 e.h1, e.h2, e.x1, e.x2, e.gs, e.tl);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the outputs expected
  // after the following rising edge.
  task automatic step(input bit ra, input bit rb, input logic [1:0] a, input logic [1:0] b,
                      input bit s, input bit f, input string nm, input bit sel,
                      input int h1, input int h2, input bit x1, input bit x2,
                      input logic [2:0] gs, input int tl);
    exp_t n;
    @(negedge clk);
    rst_a = ra; rst_b = rb; p1 = a; p2 = b; start = s; finished = f;
    n.due = pcnt + 1; n.sel = sel; n.name = nm;
    n.h1 = 4'(h1); n.h2 = 4'(h2); n.x1 = x1; n.x2 = x2; n.gs = gs; n.tl = 12'(tl);
    sb.push_back(n);
  endtask

  initial begin
    // Reset values, with and without ticks.
    step(0, 0, 2'b01, 2'b01, 1, 1, "a_reset_tick", 0, 10, 10, 0, 0, GameIdle, 3600);
    step(0, 0, 2'b00, 2'b01, 1, 0, "a_reset_notick", 0, 10, 10, 0, 0, GameIdle, 3600);
    step(0, 0, 2'b00, 2'b00, 0, 1, "b_reset", 1, 10, 10, 0, 0, GameIdle, 4);
    // After release, idle ticks change nothing.
    step(1, 0, 2'b00, 2'b00, 0, 1, "idle_rest", 0, 10, 10, 0, 0, GameIdle, 3600);
    step(1, 0, 2'b01, 2'b00, 0, 1, "idle_attack", 0, 10, 10, 0, 0, GameIdle, 3600);
    // Start with p1 already holding attack: no strike from the held level.
    step(1, 0, 2'b01, 2'b00, 1, 1, "start", 0, 10, 10, 0, 0, GameFight, 3600);
    step(1, 0, 2'b01, 2'b00, 0, 1, "held_across_start", 0, 10, 10, 0, 0, GameFight, 3599);
    step(1, 0, 2'b00, 2'b00, 0, 1, "release", 0, 10, 10, 0, 0, GameFight, 3598);
    // p1 holds attack for 5 ticks: exactly one strike.
    step(1, 0, 2'b01, 2'b00, 0, 1, "hold1", 0, 10, 8, 0, 1, GameFight, 3597);
    for (int i = 2; i <= 5; i++)
      step(1, 0, 2'b01, 2'b00, 0, 1, $sformatf("hold%0d", i), 0, 10, 8, 0, 0, GameFight,
           3598 - i);
    step(1, 0, 2'b00, 2'b00, 0, 1, "rest", 0, 10, 8, 0, 0, GameFight, 3592);
    // Strike into a block.
    step(1, 0, 2'b00, 2'b10, 0, 1, "p2_block", 0, 10, 8, 0, 0, GameFight, 3591);
    step(1, 0, 2'b01, 2'b10, 0, 1, "blocked_hit", 0, 10, 8 - BD, 0, BD != 0, GameFight, 3590);
    step(1, 0, 2'b00, 2'b00, 0, 1, "after_block", 0, 10, 8 - BD, 0, 0, GameFight, 3589);
    // Invalid 11 counts as rest, so the strike lands in full.
    step(1, 0, 2'b01, 2'b11, 0, 1, "invalid_rest", 0, 10, 6 - BD, 0, 1, GameFight, 3588);
    // No ticks: toggling inputs must not disturb anything.
    for (int i = 0; i < 4; i++)
      step(1, 0, (i % 2 == 0) ? 2'b00 : 2'b01, (i % 2 == 0) ? 2'b01 : 2'b00, 1, 0,
           $sformatf("notick%0d", i), 0, 10, 6 - BD, 0, 1, GameFight, 3588);
    // History survived the pause: p1 still 01 from the last tick, so no edge.
    step(1, 0, 2'b01, 2'b00, 0, 1, "resume_no_edge", 0, 10, 6 - BD, 0, 0, GameFight, 3587);
    // Reset mid-fight aborts the round.
    step(0, 0, 2'b01, 2'b00, 0, 1, "mid_reset", 0, 10, 10, 0, 0, GameIdle, 3600);
    step(1, 0, 2'b01, 2'b01, 0, 1, "post_reset_idle", 0, 10, 10, 0, 0, GameIdle, 3600);
    step(1, 0, 2'b00, 2'b00, 1, 1, "restart", 0, 10, 10, 0, 0, GameFight, 3600);
    // Simultaneous strikes down to a double knockout.
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 2'b01, 2'b01, 0, 1, $sformatf("both_hit%0d", k), 0, 10 - 2 * k, 10 - 2 * k,
           1, 1, (k == 5) ? GameDraw : GameFight, 3601 - 2 * k);
      if (k < 5)
        step(1, 0, 2'b00, 2'b00, 0, 1, $sformatf("both_rest%0d", k), 0, 10 - 2 * k,
             10 - 2 * k, 0, 0, GameFight, 3600 - 2 * k);
    end
    step(1, 0, 2'b00, 2'b00, 0, 1, "draw_frozen", 0, 0, 0, 0, 0, GameDraw, 3591);
    step(1, 0, 2'b01, 2'b00, 0, 1, "draw_no_strike", 0, 0, 0, 0, 0, GameDraw, 3591);
    // New round from DRAW; p2 knocks p1 out.
    step(1, 0, 2'b00, 2'b00, 1, 1, "restart2", 0, 10, 10, 0, 0, GameFight, 3600);
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 2'b00, 2'b01, 0, 1, $sformatf("p2_hit%0d", k), 0, 10 - 2 * k, 10, 1, 0,
           (k == 5) ? GameP2Win : GameFight, 3601 - 2 * k);
      if (k < 5)
        step(1, 0, 2'b00, 2'b00, 0, 1, $sformatf("p2_rest%0d", k), 0, 10 - 2 * k, 10, 0, 0,
             GameFight, 3600 - 2 * k);
    end
    step(1, 0, 2'b00, 2'b00, 0, 1, "p2win_frozen", 0, 0, 10, 0, 0, GameP2Win, 3591);
    // Short round on dut_b: timeout decided on health.
    step(1, 1, 2'b00, 2'b00, 1, 1, "b_start", 1, 10, 10, 0, 0, GameFight, 4);
    step(1, 1, 2'b01, 2'b00, 0, 1, "b_hit", 1, 10, 8, 0, 1, GameFight, 3);
    step(1, 1, 2'b00, 2'b00, 0, 1, "b_t2", 1, 10, 8, 0, 0, GameFight, 2);
    step(1, 1, 2'b00, 2'b00, 0, 1, "b_t1", 1, 10, 8, 0, 0, GameFight, 1);
    step(1, 1, 2'b00, 2'b00, 0, 1, "b_timeout", 1, 10, 8, 0, 0, GameP1Win, 0);
    step(1, 1, 2'b00, 2'b00, 0, 1, "b_frozen", 1, 10, 8, 0, 0, GameP1Win, 0);
    step(1, 1, 2'b00, 2'b00, 1, 1, "b_restart", 1, 10, 10, 0, 0, GameFight, 4);
    step(1, 1, 2'b00, 2'b00, 1, 1, "b_start_ignored", 1, 10, 10, 0, 0, GameFight, 3);
    step(1, 1, 2'b01, 2'b00, 0, 1, "b_hit_again", 1, 10, 8, 0, 1, GameFight, 2);
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      n_errors = n_errors + sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
